tc_mem_responder: RTL and testbench

//  Memory-side responder for the tensorcore request interface (AXI_out_t in / AXI_in_t out).

---
 rtl/tc_mem_responder.sv | 163 ++++++++++++++++
 tb/tb_tc_mem_responder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_mem_responder.sv
// Memory-side responder for tensorcore requests: streams read bursts out of a
// synchronous SRAM and sinks write bursts from the core into it.
module tc_mem_responder #(
    parameter int DATA_WIDTH = 256,
    parameter int MEM_AW     = 12,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           req_base,
    input  logic                  req_issend,
    input  logic [5:0]            req_burst_num,
    input  logic [2:0]            req_burst_size,
    input  logic                  req_valid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [31:0]           rsp_burst_id,
    output logic                  rsp_valid,
    output logic                  rsp_finish,
    output logic                  rsp_err,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [MEM_AW-1:0]     sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic [2:0]            fsm_state
);

    // Handshakes: req_valid is held by the core until the single-cycle arready
    // pulse; read beats are pushed with rsp_valid and cannot be stalled; a write
    // beat transfers on any cycle where wr_valid and wr_ready are both high.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_READ   = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [MEM_AW-1:0]     ADDR_ONE   = 1;
    localparam logic [RD_LATENCY-1:0] EARLY_MASK = {RD_LATENCY{1'b1}} >> 1;

    state_t                state, state_next;
    logic                  issend_q;
    logic [5:0]            num_q;
    logic [2:0]            size_q;
    logic [5:0]            cnt;
    logic [MEM_AW-1:0]     addr;
    logic                  skip;
    logic                  is_last;
    logic                  wr_beat;

    logic [RD_LATENCY-1:0] pipe_valid;
    logic [RD_LATENCY-1:0] pipe_last;
    logic [5:0]            pipe_id [RD_LATENCY];
    logic                  beat_valid;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [5:0]            hold_id;

    logic                  unused_base;
    assign unused_base = ^{req_base[4:0], req_base[31:MEM_AW+5]};

    assign skip       = (size_q != 3'd5) || (num_q == 6'd0);
    assign is_last    = (cnt == num_q - 6'd1);
    assign wr_beat    = (state == S_WRITE) && wr_valid;
    assign beat_valid = pipe_valid[RD_LATENCY-1];
    // Only the final pipeline stage may still be live when DONE hands back to IDLE.
    assign inflight   = |(pipe_valid & EARLY_MASK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (req_valid) state_next = S_ACCEPT;
            S_ACCEPT: begin
                if (skip)          state_next = S_DONE;
                else if (issend_q) state_next = S_WRITE;
                else               state_next = S_READ;
            end
            S_READ:   if (is_last) state_next = S_DONE;
            S_WRITE:  if (wr_valid && is_last) state_next = S_DONE;
            S_DONE:   if (!inflight) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issend_q <= 1'b0;
            num_q    <= '0;
            size_q   <= '0;
            cnt      <= '0;
            addr     <= '0;
        end else if (state == S_IDLE) begin
            if (req_valid) begin
                issend_q <= req_issend;
                num_q    <= req_burst_num;
                size_q   <= req_burst_size;
                cnt      <= '0;
                addr     <= req_base[MEM_AW+4:5];
            end
        end else if (state == S_READ || wr_beat) begin
            cnt  <= cnt + 6'd1;
            addr <= addr + ADDR_ONE;
        end
    end

    // Beat tags travel alongside the SRAM access so they line up with sram_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= '0;
            pipe_last  <= '0;
            for (int i = 0; i < RD_LATENCY; i++) pipe_id[i] <= '0;
        end else begin
            pipe_valid[0] <= (state == S_READ);
            pipe_last[0]  <= (state == S_READ) && is_last;
            pipe_id[0]    <= cnt;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_last[i]  <= pipe_last[i-1];
                pipe_id[i]    <= pipe_id[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data <= '0;
            hold_id   <= '0;
        end else if (beat_valid) begin
            hold_data <= sram_rdata;
            hold_id   <= pipe_id[RD_LATENCY-1];
        end
    end

    assign arready      = (state == S_ACCEPT);
    assign wr_ready     = (state == S_WRITE);
    assign rsp_valid    = beat_valid;
    assign rsp_data     = beat_valid ? sram_rdata : hold_data;
    assign rsp_burst_id = {26'd0, beat_valid ? pipe_id[RD_LATENCY-1] : hold_id};
    // Skipped and write bursts report completion from DONE; reads on their last beat.
    assign rsp_finish   = (beat_valid && pipe_last[RD_LATENCY-1])
                        || ((state == S_DONE) && (skip || issend_q));
    assign rsp_err      = (state == S_DONE) && (size_q != 3'd5);
    assign sram_en      = (state == S_READ) || wr_beat;
    assign sram_we      = wr_beat;
    assign sram_addr    = sram_en ? addr : '0;
    assign sram_wdata   = wr_beat ? wr_data : '0;
    assign fsm_state    = state;

endmodule

// File: tb/tb_tc_mem_responder.sv
// Directed bench for tc_mem_responder with a behavioural 1-cycle SRAM model.
module tb_tc_mem_responder;

    localparam int DW = 256;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   req_base = '0;
    logic          req_issend = 1'b0;
    logic [5:0]    req_burst_num = '0;
    logic [2:0]    req_burst_size = '0;
    logic          req_valid = 1'b0;
    logic          arready;
    logic [DW-1:0] rsp_data;
    logic [31:0]   rsp_burst_id;
    logic          rsp_valid;
    logic          rsp_finish;
    logic          rsp_err;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic          sram_en;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata = '0;
    logic [2:0]    fsm_state;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] mem [1 << AW];

    tc_mem_responder #(.DATA_WIDTH(DW), .MEM_AW(AW), .RD_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_base(req_base), .req_issend(req_issend), .req_burst_num(req_burst_num),
        .req_burst_size(req_burst_size), .req_valid(req_valid), .arready(arready),
        .rsp_data(rsp_data), .rsp_burst_id(rsp_burst_id), .rsp_valid(rsp_valid),
        .rsp_finish(rsp_finish), .rsp_err(rsp_err),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_en && sram_we) mem[sram_addr] <= sram_wdata;
        if (sram_en && !sram_we) sram_rdata <= mem[sram_addr];
    end

    function automatic logic [DW-1:0] rd_pat(input int k);
        return {8{32'hC0DE_0000 | 32'(k)}};
    endfunction

    function automatic logic [DW-1:0] wr_pat(input int k);
        return {8{32'h5A5A_0000 + 32'(k)}};
    endfunction

    task automatic check_idle_outputs(input string name);
        vectors++;
        if ({arready, rsp_valid, rsp_finish, rsp_err, wr_ready, sram_en, sram_we} !== 7'd0
            || rsp_data !== '0 || rsp_burst_id !== 32'd0 || sram_addr !== '0
            || sram_wdata !== '0 || fsm_state !== 3'd0) begin
            miscompares++;
            $display("FAIL %s: flags=%b id=%0d addr=%0h state=%0d, required all zero", name,
                     {arready, rsp_valid, rsp_finish, rsp_err, wr_ready, sram_en, sram_we},
                     rsp_burst_id, sram_addr, fsm_state);
        end
    endtask

    // Holds req_valid until arready; returns at the negedge of the arready cycle.
    task automatic send_req(input logic [31:0] base, input logic issend,
                            input logic [5:0] num, input logic [2:0] size);
        bit seen = 0;
        req_base = base; req_issend = issend; req_burst_num = num;
        req_burst_size = size; req_valid = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (arready) seen = 1;
        end
        req_valid = 1'b0;
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL arready_timeout: arready=0 after 10 cycles, required 1");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_reset");
    endtask

    task automatic test_read();
        int nbeats = 0;
        for (int k = 0; k < 4; k++) mem[2 + k] = rd_pat(k);
        send_req(32'h40, 1'b0, 6'd4, 3'd5);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                vectors++;
                if (arready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL read_arready_pulse: arready=%b, required 0", arready);
                end
            end
            if (rsp_valid) begin
                vectors++;
                if (cyc !== nbeats + 2 || rsp_burst_id !== 32'(nbeats)
                    || rsp_data !== rd_pat(nbeats) || rsp_finish !== (nbeats == 3)) begin
                    miscompares++;
                    $display("FAIL read_beat%0d: cyc=%0d id=%0d data=%h fin=%b, required cyc=%0d id=%0d data=%h fin=%b",
                             nbeats, cyc, rsp_burst_id, rsp_data[31:0], rsp_finish,
                             nbeats + 2, nbeats, rd_pat(nbeats) & 256'hFFFF_FFFF, nbeats == 3);
                end
                nbeats++;
            end
        end
        vectors++;
        if (nbeats !== 4) begin
            miscompares++;
            $display("FAIL read_count: beats=%0d, required 4", nbeats);
        end
        vectors++;
        if (rsp_burst_id !== 32'd3 || rsp_data !== rd_pat(3) || fsm_state !== 3'd0) begin
            miscompares++;
            $display("FAIL read_hold: id=%0d data=%h state=%0d, required id=3 data=%h state=0",
                     rsp_burst_id, rsp_data[31:0], fsm_state, rd_pat(3) & 256'hFFFF_FFFF);
        end
    endtask

    task automatic test_write();
        logic [3:0] pattern = 4'b1101;
        int beat = 0;
        send_req(32'h100, 1'b1, 6'd3, 3'd5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wr_valid = pattern[i];
            wr_data  = wr_pat(beat);
            #1;
            vectors++;
            if (wr_ready !== 1'b1 || sram_en !== pattern[i] || rsp_valid !== 1'b0
                || (pattern[i] && (sram_we !== 1'b1 || sram_addr !== AW'(8 + beat)))) begin
                miscompares++;
                $display("FAIL write_cycle%0d: rdy=%b en=%b we=%b addr=%0h rv=%b, required rdy=1 en=%b addr=%0h",
                         i, wr_ready, sram_en, sram_we, sram_addr, rsp_valid, pattern[i], 8 + beat);
            end
            if (pattern[i]) beat++;
        end
        @(negedge clk);
        wr_valid = 1'b0;
        vectors++;
        if (wr_ready !== 1'b0 || rsp_finish !== 1'b1 || rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL write_finish: rdy=%b fin=%b err=%b, required 0 1 0",
                     wr_ready, rsp_finish, rsp_err);
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (mem[8 + k] !== wr_pat(k)) begin
                miscompares++;
                $display("FAIL write_mem%0d: got %h, required %h", k,
                         mem[8 + k][31:0], wr_pat(k) & 256'hFFFF_FFFF);
            end
        end
    endtask

    task automatic test_no_beat(input string name, input logic [5:0] num,
                                input logic [2:0] size, input logic exp_err);
        send_req(32'h0, 1'b0, num, size);
        @(negedge clk);
        vectors++;
        if (rsp_finish !== 1'b1 || rsp_err !== exp_err || rsp_valid !== 1'b0 || sram_en !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_done: fin=%b err=%b rv=%b en=%b, required 1 %b 0 0",
                     name, rsp_finish, rsp_err, rsp_valid, sram_en, exp_err);
        end
        @(negedge clk);
        vectors++;
        if (rsp_finish !== 1'b0 || rsp_err !== 1'b0 || sram_en !== 1'b0 || fsm_state !== 3'd0) begin
            miscompares++;
            $display("FAIL %s_after: fin=%b err=%b en=%b state=%0d, required 0 0 0 0",
                     name, rsp_finish, rsp_err, sram_en, fsm_state);
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_addr [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        int na = 0;
        int nd = 0;
        for (int k = 0; k < 4; k++) mem[exp_addr[k]] = rd_pat(16 + k);
        send_req(32'h1FFC0, 1'b0, 6'd4, 3'd5);
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (sram_en && na < 4) begin
                vectors++;
                if (sram_addr !== exp_addr[na] || sram_we !== 1'b0) begin
                    miscompares++;
                    $display("FAIL wrap_addr%0d: addr=%0h we=%b, required %0h 0",
                             na, sram_addr, sram_we, exp_addr[na]);
                end
                na++;
            end
            if (rsp_valid && nd < 4) begin
                vectors++;
                if (rsp_data !== rd_pat(16 + nd)) begin
                    miscompares++;
                    $display("FAIL wrap_data%0d: got %h, required %h", nd,
                             rsp_data[31:0], rd_pat(16 + nd) & 256'hFFFF_FFFF);
                end
                nd++;
            end
        end
        vectors++;
        if (na !== 4 || nd !== 4) begin
            miscompares++;
            $display("FAIL wrap_count: issues=%0d beats=%0d, required 4 4", na, nd);
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        int nbeats = 0;
        send_req(32'h40, 1'b0, 6'd8, 3'd5);
        for (int i = 0; i < 12 && !hit; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_burst_id == 32'd2) hit = 1;
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL midreset_beat2: beat 2 not seen, required within 12 cycles");
        end
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_req(32'h40, 1'b0, 6'd2, 3'd5);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            if (rsp_valid) begin
                vectors++;
                if (rsp_burst_id !== 32'(nbeats) || rsp_data !== rd_pat(nbeats)
                    || rsp_finish !== (nbeats == 1)) begin
                    miscompares++;
                    $display("FAIL post_reset_beat%0d: id=%0d data=%h fin=%b, required id=%0d data=%h",
                             nbeats, rsp_burst_id, rsp_data[31:0], rsp_finish,
                             nbeats, rd_pat(nbeats) & 256'hFFFF_FFFF);
                end
                nbeats++;
            end
        end
        vectors++;
        if (nbeats !== 2) begin
            miscompares++;
            $display("FAIL post_reset_count: beats=%0d, required 2", nbeats);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        test_reset();
        test_read();
        test_write();
        test_no_beat("bad_size", 6'd8, 3'd4, 1'b1);
        test_no_beat("zero_num", 6'd0, 3'd5, 1'b0);
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
